ram_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single-port data RAM (ram_top: ram_addr/ram_wdata/ram_wen/ram_rdata) between the CPU MEM stage (port 0) and a loader/debug DMA requester (port 1). Each port uses a req/gnt handshake plus a read-return pulse. The block generates all RAM control with registered outputs. It sits between the MEM stage, the loader and ram_top.

---
 rtl/ram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of a single-port synchronous-read RAM.
// Define RAM_ARB_PERF_EN to add the saturating conflict_cnt output.
module ram_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 32,
   parameter int RAM_RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_wen,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
`ifdef RAM_ARB_PERF_EN
   ,
   output logic [31:0]       conflict_cnt
`endif
);

   localparam int CNT_W = (RAM_RD_LAT > 1) ? $clog2(RAM_RD_LAT) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RESP} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_gnt_q, last_gnt_d;
   logic              port_q, port_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              ram_wen_q, ram_wen_d;
   logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic              win;

   always_comb begin
      // On a tie the port that was not served last wins
      win         = (req0 && req1) ? ~last_gnt_q : req1;
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_gnt_d  = last_gnt_q;
      port_d      = port_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_wen_d   = 1'b0;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      rvalid0_d   = 1'b0;
      rvalid1_d   = 1'b0;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               ram_addr_d  = win ? addr1  : addr0;
               ram_wdata_d = win ? wdata1 : wdata0;
               ram_wen_d   = win ? we1    : we0;
               gnt0_d      = ~win;
               gnt1_d      = win;
               last_gnt_d  = win;
               port_d      = win;
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            // ram_wen_q still carries the granted request's direction here
            if (ram_wen_q) begin
               state_d = IDLE;
            end else begin
               cnt_d   = CNT_W'(RAM_RD_LAT - 1);
               state_d = RDWAIT;
            end
         end
         RDWAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               if (port_q) begin
                  rdata1_d  = ram_rdata;
                  rvalid1_d = 1'b1;
               end else begin
                  rdata0_d  = ram_rdata;
                  rvalid0_d = 1'b1;
               end
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         last_gnt_q  <= 1'b1;
         port_q      <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_wen_q   <= 1'b0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_gnt_q  <= last_gnt_d;
         port_q      <= port_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_wen_q   <= ram_wen_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         rvalid0_q   <= rvalid0_d;
         rvalid1_q   <= rvalid1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
      end
   end

   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign ram_wen   = ram_wen_q;
   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign rvalid0   = rvalid0_q;
   assign rvalid1   = rvalid1_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign busy      = (state_q != IDLE);

`ifdef RAM_ARB_PERF_EN
   logic [31:0] conflict_q, conflict_d;

   always_comb begin
      conflict_d = conflict_q;
      if (state_q == IDLE && req0 && req1 && conflict_q != 32'hFFFF_FFFF) begin
         conflict_d = conflict_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_q <= '0;
      end else begin
         conflict_q <= conflict_d;
      end
   end

   assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed steps plus randomized traffic against a
// cycle-scheduled reference model of the arbitration rules and a model memory.
module tb_ram_arbiter;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam int LAT    = 1;

   typedef struct packed {
      logic [1:0]        g;
      logic [1:0]        r;
      logic              acc;
      logic              wen;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wd;
      logic [DATA_W-1:0] rd;
   } slot_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wd;
   } txn_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0]        req_v, we_v;
   logic [ADDR_W-1:0] addr_v [2];
   logic [DATA_W-1:0] wd_v [2];
   logic              gnt0, gnt1, rvalid0, rvalid1, ram_wen, busy;
   logic [DATA_W-1:0] rdata0, rdata1, ram_wdata, ram_rdata;
   logic [ADDR_W-1:0] ram_addr;
`ifdef RAM_ARB_PERF_EN
   logic [31:0]       conflict_cnt;
`endif
   logic [DATA_W-1:0] ram_mem [0:65535];

   always #5 clk = ~clk;

   ram_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req_v[0]), .we0(we_v[0]), .addr0(addr_v[0]), .wdata0(wd_v[0]),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req_v[1]), .we1(we_v[1]), .addr1(addr_v[1]), .wdata1(wd_v[1]),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
      .ram_rdata(ram_rdata), .busy(busy)
`ifdef RAM_ARB_PERF_EN
      , .conflict_cnt(conflict_cnt)
`endif
   );

   // Stand-in for ram_top: one-cycle synchronous read
   always @(posedge clk) begin
      if (ram_wen) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
   end

   int n_checks = 0, n_pass = 0, n_fail = 0;
   int cyc = 0, next_free = 0, last = 1, conflicts_model = 0;
   int gap_pct = 0, first_gnt = -1, rv1_seen = 0;
   logic [DATA_W-1:0] model_mem [0:65535];
   logic [DATA_W-1:0] exp_rd [2];
   slot_t slots [16];
   txn_t  pq0[$], pq1[$];
   logic [1:0] done_v;
   int gnt_log[$];
   logic [DATA_W-1:0] rd_log0[$], rd_log1[$];

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      next_free = 0;
      last = 1;
      conflicts_model = 0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      foreach (slots[i]) slots[i] = '0;
      pq0.delete();
      pq1.delete();
      req_v  = 2'b00;
      done_v = 2'b00;
   endtask

   task automatic present_port(int p);
      txn_t t;
      if (req_v[p]) return;
      if ((p == 0) ? (pq0.size() == 0) : (pq1.size() == 0)) return;
      if ($urandom_range(99) < gap_pct) return;
      t = (p == 0) ? pq0[0] : pq1[0];
      req_v[p]  = 1'b1;
      we_v[p]   = t.we;
      addr_v[p] = t.addr;
      wd_v[p]   = t.wd;
   endtask

   task automatic do_cycle();
      int w, s;
      slot_t cur;
      // Model: an idle arbiter serves the sampled request(s) and is busy for a fixed span
      if (rst_n && cyc >= next_free && req_v != 2'b00) begin
         if (req_v == 2'b11) begin
            w = 1 - last;
            conflicts_model++;
         end else begin
            w = req_v[1] ? 1 : 0;
         end
         last = w;
         s = (cyc + 1) % 16;
         slots[s].g[w] = 1'b1;
         slots[s].acc  = 1'b1;
         slots[s].wen  = we_v[w];
         slots[s].addr = addr_v[w];
         slots[s].wd   = wd_v[w];
         if (we_v[w]) begin
            model_mem[addr_v[w]] = wd_v[w];
            next_free = cyc + 2;
         end else begin
            s = (cyc + LAT + 2) % 16;
            slots[s].r[w] = 1'b1;
            slots[s].rd   = model_mem[addr_v[w]];
            next_free = cyc + LAT + 3;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      cur = slots[cyc % 16];
      slots[cyc % 16] = '0;
      if (cur.r[0]) exp_rd[0] = cur.rd;
      if (cur.r[1]) exp_rd[1] = cur.rd;
      chk("gnt0", gnt0, cur.g[0]);
      chk("gnt1", gnt1, cur.g[1]);
      chk("rvalid0", rvalid0, cur.r[0]);
      chk("rvalid1", rvalid1, cur.r[1]);
      chk("rdata0", rdata0, exp_rd[0]);
      chk("rdata1", rdata1, exp_rd[1]);
      chk("ram_wen", ram_wen, cur.wen);
      chk("busy", busy, cyc < next_free);
      if (cur.acc) begin
         chk("ram_addr", ram_addr, cur.addr);
         if (cur.wen) chk("ram_wdata", ram_wdata, cur.wd);
      end
`ifdef RAM_ARB_PERF_EN
      chk("conflict_cnt", conflict_cnt, conflicts_model);
`endif
      if ((gnt0 || gnt1) && first_gnt < 0) first_gnt = cyc;
      if (gnt0) gnt_log.push_back(0);
      if (gnt1) gnt_log.push_back(1);
      if (gnt0 && ram_wen) $display("txn port0 wr addr=0x%04h data=0x%08h", ram_addr, ram_wdata);
      if (gnt1 && ram_wen) $display("txn port1 wr addr=0x%04h data=0x%08h", ram_addr, ram_wdata);
      if (rvalid0) begin
         rd_log0.push_back(rdata0);
         $display("txn port0 rd data=0x%08h", rdata0);
      end
      if (rvalid1) begin
         rd_log1.push_back(rdata1);
         rv1_seen++;
         $display("txn port1 rd data=0x%08h", rdata1);
      end
      // Requesters release on the edge after they sampled their grant
      if (done_v[0]) begin
         if (pq0.size() > 0) void'(pq0.pop_front());
         req_v[0] = 1'b0;
      end
      if (done_v[1]) begin
         if (pq1.size() > 0) void'(pq1.pop_front());
         req_v[1] = 1'b0;
      end
      done_v = {gnt1, gnt0} & req_v;
      present_port(0);
      present_port(1);
   endtask

   task automatic run(string tag, int max_cyc);
      int n;
      n = 0;
      present_port(0);
      present_port(1);
      while (!(pq0.size() == 0 && pq1.size() == 0 && req_v == 2'b00 && cyc >= next_free)
             && n < max_cyc) begin
         do_cycle();
         n++;
      end
      chk({tag, "_done"}, n < max_cyc, 1'b1);
   endtask

   task automatic push(int p, logic we, int addr, logic [DATA_W-1:0] wd);
      txn_t t;
      t.we   = we;
      t.addr = ADDR_W'(addr);
      t.wd   = wd;
      if (p == 0) pq0.push_back(t);
      else        pq1.push_back(t);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, n;
      int exp_order[$];
      logic [DATA_W-1:0] exp_data[$];

      req_v = 2'b00;
      we_v  = 2'b00;
      addr_v[0] = '0; addr_v[1] = '0;
      wd_v[0] = '0;   wd_v[1] = '0;
      model_reset();

      // Reset held with random inputs: every output stays 0
      for (int i = 0; i < 4; i++) begin
         req_v = 2'($urandom);
         we_v  = 2'($urandom);
         addr_v[0] = 16'($urandom); addr_v[1] = 16'($urandom);
         wd_v[0] = $urandom; wd_v[1] = $urandom;
         @(posedge clk);
         #1;
         chk("rst_gnt", {gnt1, gnt0}, 2'b00);
         chk("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
         chk("rst_rdata", {rdata1, rdata0}, 64'h0);
         chk("rst_ram_bus", {ram_addr, ram_wdata, ram_wen}, 49'h0);
         chk("rst_busy", busy, 1'b0);
`ifdef RAM_ARB_PERF_EN
         chk("rst_conflict", conflict_cnt, 32'h0);
`endif
      end
      model_reset();
      rst_n = 1'b1;

      // Preload through port 0; the first grant must follow its request by one cycle
      c0 = cyc;
      for (int i = 0; i < 256; i++) push(0, 1'b1, i, 32'hA500_0000 | i);
      run("preload", 1000);
      chk("first_gnt_latency", first_gnt - c0, 1);

      // Port 0 write then read of 0x0001
      rd_log0.delete();
      push(0, 1'b1, 16'h0001, 32'h7);
      push(0, 1'b0, 16'h0001, 32'h0);
      run("wr_rd", 50);
      chk("wr_rd_count", rd_log0.size(), 1);
      chk("wr_rd_data", (rd_log0.size() > 0) ? rd_log0[0] : 32'hDEAD_BEEF, 32'h7);
      repeat (3) do_cycle();
      chk("rdata0_hold", rdata0, 32'h7);

      // Port 1 served alone first, then both ports stream reads and alternate
      push(1, 1'b0, 16'h0003, 32'h0);
      run("p1_single", 50);
      gnt_log.delete(); rd_log0.delete(); rd_log1.delete();
      push(0, 1'b0, 16'h0002, 32'h0); push(0, 1'b0, 16'h0002, 32'h0);
      push(1, 1'b0, 16'h0003, 32'h0); push(1, 1'b0, 16'h0003, 32'h0);
      run("rr", 100);
      exp_order = '{0, 1, 0, 1};
      chk("rr_order_len", gnt_log.size(), exp_order.size());
      foreach (exp_order[i]) chk("rr_order", (i < gnt_log.size()) ? gnt_log[i] : -1, exp_order[i]);
      exp_data = '{32'hA500_0002, 32'hA500_0002};
      foreach (exp_data[i]) chk("rr_data0", (i < rd_log0.size()) ? rd_log0[i] : 32'hDEAD_BEEF, exp_data[i]);
      exp_data = '{32'hA500_0003, 32'hA500_0003};
      foreach (exp_data[i]) chk("rr_data1", (i < rd_log1.size()) ? rd_log1[i] : 32'hDEAD_BEEF, exp_data[i]);

      // Same-address read (port 0) against write (port 1) in one arbitration
      push(1, 1'b1, 16'h0010, 32'h5);
      run("seed10", 50);
      gnt_log.delete(); rd_log0.delete();
      push(0, 1'b0, 16'h0010, 32'h0);
      push(0, 1'b0, 16'h0010, 32'h0);
      push(1, 1'b1, 16'h0010, 32'h9);
      run("same_addr", 100);
      exp_order = '{0, 1, 0};
      chk("same_order_len", gnt_log.size(), exp_order.size());
      foreach (exp_order[i]) chk("same_order", (i < gnt_log.size()) ? gnt_log[i] : -1, exp_order[i]);
      exp_data = '{32'h5, 32'h9};
      foreach (exp_data[i]) chk("same_data", (i < rd_log0.size()) ? rd_log0[i] : 32'hDEAD_BEEF, exp_data[i]);

      // Reset pulse while a port 1 read is waiting on the RAM
      push(1, 1'b0, 16'h0003, 32'h0);
      present_port(1);
      n = 0;
      while (!gnt1 && n < 10) begin
         do_cycle();
         n++;
      end
      chk("rst_mid_gnt1", gnt1, 1'b1);
      do_cycle();
      chk("rst_mid_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_wen", ram_wen, 1'b0);
      chk("rst_mid_rdata1", rdata1, 32'h0);
      chk("rst_mid_rvalid", {rvalid1, rvalid0}, 2'b00);
      chk("rst_mid_idle", busy, 1'b0);
      model_reset();
      do_cycle();
      do_cycle();
      rst_n = 1'b1;
      rv1_seen = 0;
      repeat (8) do_cycle();
      chk("rst_mid_no_rvalid1", rv1_seen, 0);

`ifdef RAM_ARB_PERF_EN
      // Three contested arbitrations, then an uncontested one
      push(0, 1'b1, 16'h0020, 32'h1); push(0, 1'b1, 16'h0021, 32'h2);
      push(1, 1'b1, 16'h0022, 32'h3); push(1, 1'b1, 16'h0023, 32'h4);
      run("perf", 100);
      chk("perf_conflicts", conflict_cnt, 32'd3);
      push(0, 1'b0, 16'h0020, 32'h0);
      run("perf_single", 50);
      chk("perf_unchanged", conflict_cnt, 32'd3);
`endif

      // Randomized traffic on a small address window to provoke hazards
      gap_pct = 30;
      for (int i = 0; i < 150; i++) begin
         push(0, 1'($urandom), $urandom_range(15), $urandom);
         push(1, 1'($urandom), $urandom_range(15), $urandom);
      end
      run("random", 6000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
